aes_load_interface: RTL

- Parametrised successor to the byte-serial AES input loader.
- Accepts plaintext and key beats of configurable width over a valid/ready command port and assembles a 128-bit block plus a 128/192/256-bit key.
- Issues a one-cycle start pulse to the AES engine and holds the operands stable until the engine reports done.
- Sits between the host/UART-side command source and the AES engine core.

---
 rtl/aes_load_interface.sv | 115 +++++++++++
 1 files changed

// File: rtl/aes_load_interface.sv
// Assembles plaintext and key beats for the AES engine, fires a one-cycle
// start pulse and holds the operands until the engine reports done.
module aes_load_interface #(
    parameter int unsigned DIN_W    = 8,
    parameter int unsigned KEY_W    = 128,
    parameter bit          KEEP_KEY = 1'b1
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic [DIN_W-1:0] din,
    input  logic [1:0]       cmd,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             engine_done,
    output logic             engine_start,
    output logic [127:0]     plain_out,
    output logic [KEY_W-1:0] key_out,
    output logic             plain_loaded,
    output logic             key_loaded,
    output logic             err
);

    localparam int unsigned PT_BEATS  = 128 / DIN_W;
    localparam int unsigned KEY_BEATS = KEY_W / DIN_W;
    localparam int unsigned PT_CW     = $clog2(PT_BEATS + 1);
    localparam int unsigned KEY_CW    = $clog2(KEY_BEATS + 1);

    typedef enum logic [1:0] {StIdle, StStart, StBusy} state_e;

    state_e            state_q;
    logic [PT_CW-1:0]  pt_cnt_q;
    logic [KEY_CW-1:0] key_cnt_q;
    logic              accept;

    assign cmd_ready = (state_q == StIdle);
    assign accept    = cmd_valid && cmd_ready;

    always_ff @(posedge clk) begin
        if (rst_) begin
            state_q      <= StIdle;
            pt_cnt_q     <= '0;
            key_cnt_q    <= '0;
            plain_out    <= '0;
            key_out      <= '0;
            plain_loaded <= 1'b0;
            key_loaded   <= 1'b0;
            engine_start <= 1'b0;
            err          <= 1'b0;
        end else begin
            engine_start <= 1'b0;
            err          <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        case (cmd)
                            2'b01: begin
                                // A beat after a complete block starts a fresh block.
                                if (plain_loaded) begin
                                    plain_out    <= {{(128-DIN_W){1'b0}}, din};
                                    pt_cnt_q     <= PT_CW'(1);
                                    plain_loaded <= 1'b0;
                                end else begin
                                    plain_out <= {plain_out[127-DIN_W:0], din};
                                    pt_cnt_q  <= pt_cnt_q + PT_CW'(1);
                                    if (pt_cnt_q == PT_CW'(PT_BEATS - 1)) begin
                                        plain_loaded <= 1'b1;
                                    end
                                end
                            end
                            2'b10: begin
                                if (key_loaded) begin
                                    key_out    <= {{(KEY_W-DIN_W){1'b0}}, din};
                                    key_cnt_q  <= KEY_CW'(1);
                                    key_loaded <= 1'b0;
                                end else begin
                                    key_out   <= {key_out[KEY_W-1-DIN_W:0], din};
                                    key_cnt_q <= key_cnt_q + KEY_CW'(1);
                                    if (key_cnt_q == KEY_CW'(KEY_BEATS - 1)) begin
                                        key_loaded <= 1'b1;
                                    end
                                end
                            end
                            2'b11: begin
                                if (plain_loaded && key_loaded) begin
                                    state_q      <= StStart;
                                    engine_start <= 1'b1;
                                end else begin
                                    err <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                StStart, StBusy: begin
                    if (engine_done) begin
                        state_q      <= StIdle;
                        plain_out    <= '0;
                        pt_cnt_q     <= '0;
                        plain_loaded <= 1'b0;
                        if (!KEEP_KEY) begin
                            key_out    <= '0;
                            key_cnt_q  <= '0;
                            key_loaded <= 1'b0;
                        end
                    end else begin
                        state_q <= StBusy;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
